// File: rtl/spireg_master.sv
// rtl/spireg_master.sv - SPI mode-0 master issuing single-register read/write frames to a spireg slave
//
// Purpose:
//   Accepts one register request on a valid/ready handshake and turns it into a
//   single SPI frame: an 8-bit header (bit7 = write, low bits = address) followed
//   by REG_W data bits, MSB first. Read data comes back on a one-cycle rsp_valid.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   req_valid/ready request handshake; req_write/req_addr/req_wdata captured on accept
//   rsp_valid       one-cycle pulse at the end of every completed frame
//   rsp_rdata       read data (0 for writes), held until the next rsp_valid
//   busy            high from acceptance until req_ready returns
//   sclk/nss/mosi   SPI outputs (sclk idle low, nss active low)
//   miso            SPI input, asynchronous to clk
module spireg_master #(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [REG_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [REG_W-1:0]  rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              nss,
    output logic              mosi,
    input  logic              miso
);

    localparam int N     = 8 + REG_W;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(N) + 1;
    localparam int GAP_W = $clog2(CS_GAP) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;   // 0 = sclk low phase, 1 = sclk high phase
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [N-1:0]       tx_q, tx_d;
    logic [REG_W-1:0]   rx_q, rx_d;
    logic               wr_q, wr_d;
    logic               miso_s1_q, miso_s2_q;

    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [REG_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               busy_q, busy_d;
    logic               sclk_q, sclk_d;
    logic               nss_q, nss_d;
    logic               mosi_q, mosi_d;

    logic [7:0]         hdr;
    logic [N-1:0]       frame;
    logic               div_end;

    // Header bits [6:ADDR_W] come out as zero from the zero-extending cast.
    always_comb begin
        hdr    = 8'(req_addr);
        hdr[7] = req_write;
        frame  = {hdr, (req_write ? req_wdata : {REG_W{1'b0}})};
    end

    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        sclk_d      = sclk_q;
        nss_d       = nss_q;
        mosi_d      = mosi_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SHIFT;
                    tx_d        = frame;
                    wr_d        = req_write;
                    mosi_d      = frame[N-1];
                    nss_d       = 1'b0;
                    sclk_d      = 1'b0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    div_d       = '0;
                    phase_d     = 1'b0;
                    bit_d       = '0;
                end
            end

            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        // Last clk cycle of the high phase: take the synchronized miso.
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        rx_d    = {rx_q[REG_W-2:0], miso_s2_q};
                        if (bit_q == BIT_W'(N - 1)) begin
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[N-2];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            HOLD: begin
                if (div_end) begin
                    state_d     = GAP;
                    nss_d       = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? {REG_W{1'b0}} : rx_q;
                    gap_d       = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            gap_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            nss_q       <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            miso_s1_q   <= miso;
            miso_s2_q   <= miso_s1_q;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            sclk_q      <= sclk_d;
            nss_q       <= nss_d;
            mosi_q      <= mosi_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign nss       = nss_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spireg_master.sv
// tb/tb_spireg_master.sv - self-checking bench for spireg_master with an SPI register-slave model
module tb_spireg_master;

    localparam int N = 16;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [2:0] req_addr  = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, busy, sclk, nss, mosi, miso;
    logic [7:0] rsp_rdata;

    logic       r6_valid = 1'b0;
    logic       r6_write = 1'b0;
    logic [2:0] r6_addr  = '0;
    logic [7:0] r6_wdata = '0;
    logic       r6_miso  = 1'b0;
    logic       r6_ready, r6_rsp_valid, r6_busy, r6_sclk, r6_nss, r6_mosi;
    logic [7:0] r6_rdata;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spireg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(4), .CS_GAP(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sclk(sclk), .nss(nss), .mosi(mosi), .miso(miso)
    );

    spireg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(6), .CS_GAP(2)) dut6 (
        .clk(clk), .rst(rst),
        .req_valid(r6_valid), .req_ready(r6_ready), .req_write(r6_write),
        .req_addr(r6_addr), .req_wdata(r6_wdata),
        .rsp_valid(r6_rsp_valid), .rsp_rdata(r6_rdata), .busy(r6_busy),
        .sclk(r6_sclk), .nss(r6_nss), .mosi(r6_mosi), .miso(r6_miso)
    );

    // Scoreboard queues: expectations pushed when a request is driven.
    logic [15:0] exp_frame_q[$];
    logic [7:0]  exp_rsp_q[$];
    int          nss_fall_q[$];
    int          nss_rise_q[$];
    int          r6_rise_q[$];
    int          rsp_cnt      = 0;
    int          last_rsp_cyc = -1;
    int          r6_rsp_cyc   = -1;
    logic [7:0]  r6_rsp_data  = 8'hxx;
    logic        nss_prev     = 1'b1;
    logic        r6_sclk_prev = 1'b0;
    logic [15:0] exp_f;
    logic [7:0]  exp_r;

    // SPI register-slave model (mode 0).
    logic [7:0]  mem [8];
    int          s_cnt  = 0;
    logic [15:0] s_sh   = '0;
    logic [7:0]  s_hdr  = '0;
    logic [7:0]  s_byte = '0;
    logic        s_miso = 1'b0;
    assign miso = s_miso;

    always @(negedge nss) begin
        s_cnt  = 0;
        s_sh   = '0;
        s_miso = 1'b0;
    end

    always @(posedge sclk) begin
        if (nss === 1'b0) begin
            s_sh = {s_sh[14:0], mosi};
            s_cnt++;
            if (s_cnt == 8) s_hdr = s_sh[7:0];
        end
    end

    always @(negedge sclk) begin
        if (nss === 1'b0) begin
            s_byte = mem[s_hdr[2:0]];
            if (s_cnt >= 8 && s_cnt < 16 && s_hdr[7] == 1'b0) s_miso = s_byte[15 - s_cnt];
            else s_miso = 1'b0;
        end
    end

    // Frame scoreboard: compare each completed frame against the next expectation.
    always @(posedge nss) begin
        if (rst === 1'b0) begin
            checks++;
            if (exp_frame_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected got=%h bits=%0d", s_sh, s_cnt);
            end else begin
                exp_f = exp_frame_q.pop_front();
                if (s_sh !== exp_f || s_cnt != N) begin
                    errors++;
                    $display("FAIL frame got=%h bits=%0d exp=%h bits=%0d", s_sh, s_cnt, exp_f, N);
                end
            end
            if (s_cnt == N && s_hdr[7] == 1'b1) mem[s_hdr[2:0]] = s_sh[7:0];
        end
    end

    // Response scoreboard and edge-time monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (nss_prev === 1'b1 && nss === 1'b0) nss_fall_q.push_back(cyc);
        if (nss_prev === 1'b0 && nss === 1'b1) nss_rise_q.push_back(cyc);
        nss_prev = nss;
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            checks++;
            if (exp_rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got=%h", rsp_rdata);
            end else begin
                exp_r = exp_rsp_q.pop_front();
                if (rsp_rdata !== exp_r) begin
                    errors++;
                    $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, exp_r);
                end
            end
        end
        if (r6_sclk_prev === 1'b0 && r6_sclk === 1'b1) r6_rise_q.push_back(cyc);
        r6_sclk_prev = r6_sclk;
        if (r6_rsp_valid === 1'b1) begin
            r6_rsp_cyc  = cyc;
            r6_rsp_data = r6_rdata;
        end
    end

    function automatic logic [15:0] mkframe(input logic w, input logic [2:0] a, input logic [7:0] d);
        return {w, 4'b0000, a, (w ? d : 8'h00)};
    endfunction

    // Called on a negedge; returns on the negedge of T0+1.
    task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d,
                        input bit keep, output int t0, output bit ok);
        ok        = 1'b0;
        t0        = -1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready === 1'b1) begin
                t0 = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (req_ready === 1'b1 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy, sclk, nss, mosi} !== 6'b100010) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, rsp_valid, busy, sclk, nss, mosi}, 6'b100010);
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata got=%h exp=00", rsp_rdata);
        end
    endtask

    task automatic test_write();
        int t0;
        bit ok;
        nss_fall_q.delete();
        nss_rise_q.delete();
        exp_frame_q.push_back(mkframe(1'b1, 3'd2, 8'hA5));
        exp_rsp_q.push_back(8'h00);
        send(1'b1, 3'd2, 8'hA5, 1'b0, t0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept got=timeout exp=accept"); end
        checks++;
        if ({busy, nss, sclk, mosi, req_ready} !== 5'b10010) begin
            errors++;
            $display("FAIL write_t0p1 got=%b exp=%b", {busy, nss, sclk, mosi, req_ready}, 5'b10010);
        end
        while (cyc < t0 + 134) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL write_ready_early got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_t135 got=%b%b exp=10", req_ready, busy);
        end
        checks++;
        if (last_rsp_cyc != t0 + 133) begin
            errors++;
            $display("FAIL write_rsp_time got=%0d exp=%0d", last_rsp_cyc - t0, 133);
        end
        checks++;
        if (nss_fall_q.size() != 1 || nss_rise_q.size() != 1) begin
            errors++;
            $display("FAIL write_nss_edges got=%0d/%0d exp=1/1", nss_fall_q.size(), nss_rise_q.size());
        end else if (nss_fall_q[0] != t0 + 1 || nss_rise_q[0] != t0 + 133) begin
            errors++;
            $display("FAIL write_nss_time got=%0d/%0d exp=1/133", nss_fall_q[0] - t0, nss_rise_q[0] - t0);
        end
    endtask

    task automatic test_read();
        int t0;
        bit ok;
        logic [7:0] pats [2];
        pats[0] = 8'h3C;
        pats[1] = 8'hC3;
        exp_frame_q.push_back(mkframe(1'b0, 3'd6, 8'h00));
        exp_rsp_q.push_back(8'h3C);
        send(1'b0, 3'd6, 8'hFF, 1'b0, t0, ok);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_idle got=timeout exp=idle"); end
        checks++;
        if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL read_hold got=%h exp=3c", rsp_rdata); end
        for (int i = 0; i < 2; i++) begin
            exp_frame_q.push_back(mkframe(1'b1, 3'd6, pats[i]));
            exp_rsp_q.push_back(8'h00);
            send(1'b1, 3'd6, pats[i], 1'b0, t0, ok);
            wait_idle(ok);
            exp_frame_q.push_back(mkframe(1'b0, 3'd6, 8'h00));
            exp_rsp_q.push_back(pats[i]);
            send(1'b0, 3'd6, 8'h00, 1'b0, t0, ok);
            wait_idle(ok);
            checks++;
            if (!ok || rsp_rdata !== pats[i]) begin
                errors++;
                $display("FAIL loopback got=%h exp=%h", rsp_rdata, pats[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0a, t0b;
        bit ok;
        nss_fall_q.delete();
        nss_rise_q.delete();
        exp_frame_q.push_back(mkframe(1'b1, 3'd3, 8'h11));
        exp_rsp_q.push_back(8'h00);
        exp_frame_q.push_back(mkframe(1'b0, 3'd3, 8'h00));
        exp_rsp_q.push_back(8'h11);
        send(1'b1, 3'd3, 8'h11, 1'b1, t0a, ok);
        send(1'b0, 3'd3, 8'hEE, 1'b0, t0b, ok);
        wait_idle(ok);
        checks++;
        if (t0b != t0a + 135) begin
            errors++;
            $display("FAIL b2b_accept got=%0d exp=%0d", t0b - t0a, 135);
        end
        checks++;
        if (nss_fall_q.size() != 2 || nss_rise_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_edges got=%0d/%0d exp=2/2", nss_fall_q.size(), nss_rise_q.size());
        end else if (nss_fall_q[1] - nss_rise_q[0] != 3) begin
            errors++;
            $display("FAIL b2b_gap got=%0d exp=3", nss_fall_q[1] - nss_rise_q[0]);
        end
    endtask

    task automatic test_busy_ignore();
        int t0, rsp0;
        bit ok;
        nss_fall_q.delete();
        rsp0 = rsp_cnt;
        exp_frame_q.push_back(mkframe(1'b1, 3'd1, 8'h5A));
        exp_rsp_q.push_back(8'h00);
        send(1'b1, 3'd1, 8'h5A, 1'b0, t0, ok);
        repeat (4) @(negedge clk);
        req_wdata = 8'hFF;
        req_addr  = 3'd7;
        req_write = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 3'd5;
        req_write = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle(ok);
        repeat (30) @(negedge clk);
        checks++;
        if (rsp_cnt - rsp0 != 1 || nss_fall_q.size() != 1) begin
            errors++;
            $display("FAIL busy_ignore got=%0d rsp %0d frames exp=1 rsp 1 frames", rsp_cnt - rsp0, nss_fall_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int t0, rsp0;
        bit ok;
        rsp0 = rsp_cnt;
        send(1'b1, 3'd4, 8'h77, 1'b0, t0, ok);
        while (cyc < t0 + 40) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({nss, sclk, mosi, busy, rsp_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL midreset_out got=%b exp=%b", {nss, sclk, mosi, busy, rsp_valid}, 5'b10000);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_cnt != rsp0) begin
            errors++;
            $display("FAIL midreset_after got=%b,%0d exp=1,0", req_ready, rsp_cnt - rsp0);
        end
        exp_frame_q.push_back(mkframe(1'b1, 3'd4, 8'h77));
        exp_rsp_q.push_back(8'h00);
        send(1'b1, 3'd4, 8'h77, 1'b0, t0, ok);
        wait_idle(ok);
        checks++;
        if (!ok || rsp_cnt != rsp0 + 1 || last_rsp_cyc != t0 + 133) begin
            errors++;
            $display("FAIL midreset_next got=%0d rsp at %0d exp=1 rsp at 133", rsp_cnt - rsp0, last_rsp_cyc - t0);
        end
    endtask

    task automatic test_clkdiv6();
        int t0;
        r6_rise_q.delete();
        r6_write = 1'b1;
        r6_addr  = 3'd1;
        r6_wdata = 8'h99;
        r6_valid = 1'b1;
        t0       = -1;
        for (int i = 0; i < 50; i++) begin
            if (r6_ready === 1'b1) begin
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        r6_valid = 1'b0;
        for (int i = 0; i < 400 && r6_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (r6_rise_q.size() != 16) begin
            errors++;
            $display("FAIL div6_rises got=%0d exp=16", r6_rise_q.size());
        end else if (r6_rise_q[0] != t0 + 7 || r6_rise_q[1] - r6_rise_q[0] != 12) begin
            errors++;
            $display("FAIL div6_sclk got=%0d,%0d exp=7,12", r6_rise_q[0] - t0, r6_rise_q[1] - r6_rise_q[0]);
        end
        checks++;
        if (r6_rsp_cyc != t0 + 199 || r6_rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL div6_rsp got=%0d/%h exp=199/00", r6_rsp_cyc - t0, r6_rsp_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[6] = 8'h3C;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_clkdiv6();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_frame_q.size() != 0 || exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d frames %0d rsps exp=0", exp_frame_q.size(), exp_rsp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
